// File: rtl/ram_arb_pkg.sv
// Shared types and width helpers for the RAM port arbiter.
package ram_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam int unsigned STAT_W = 16;

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// Round-robin picker: first valid requester at or after ptr_i, wrapping mod NREQ.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = 2
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    int unsigned j;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        j       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = (32'(ptr_i) + k) % NREQ;
            if (!any_o && valid_i[j]) begin
                any_o      = 1'b1;
                idx_o      = IW'(j);
                grant_o[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one RAM write port and async read port.
// Optional per-requester beat counters when RAM_ARB_STATS_EN is defined.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ-1:0]            req_we,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NREQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NREQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]      resp_data,
    output logic                       ram_we,
    output logic [ADDR_WIDTH-1:0]      ram_write_addr,
    output logic [DATA_WIDTH-1:0]      ram_write_data,
    output logic [ADDR_WIDTH-1:0]      ram_read_addr,
    input  logic [DATA_WIDTH-1:0]      ram_read_data
`ifdef RAM_ARB_STATS_EN
    ,
    output logic [NREQ*STAT_W-1:0]     grant_count
`endif
);

    localparam int unsigned IW = idx_width(NREQ);
    localparam int unsigned CW = idx_width(BURST_LEN + 1);

    arb_state_e            state_q, state_d;
    logic [IW-1:0]         owner_q, owner_d;
    logic [CW-1:0]         beat_cnt_q, beat_cnt_d;
    logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]       resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;

    logic [NREQ-1:0] pick_grant;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic            keep;
    logic            gnt_vld;
    logic [IW-1:0]   gnt_idx;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .valid_i (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // Grant is gated by rst so an async reset drops it in the same cycle.
    always_comb begin
        keep    = (state_q == ARB_BUSY) && req_valid[owner_q] && (beat_cnt_q < CW'(BURST_LEN));
        gnt_vld = !rst && (keep || pick_any);
        gnt_idx = keep ? owner_q : pick_idx;
    end

    assign req_ready      = gnt_vld ? (NREQ'(1) << gnt_idx) : '0;
    assign ram_write_addr = gnt_vld ? req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign ram_read_addr  = ram_write_addr;
    assign ram_write_data = gnt_vld ? req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign ram_we         = gnt_vld && req_we[gnt_idx];

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        beat_cnt_d   = beat_cnt_q;
        rr_ptr_d     = rr_ptr_q;
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        if (keep) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
        end else if (pick_any) begin
            state_d    = ARB_BUSY;
            owner_d    = pick_idx;
            beat_cnt_d = CW'(1);
            rr_ptr_d   = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
        end else begin
            state_d    = ARB_IDLE;
            beat_cnt_d = '0;
        end
        if (gnt_vld && !req_we[gnt_idx]) begin
            resp_valid_d = req_ready;
            resp_data_d  = ram_read_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            owner_q      <= '0;
            beat_cnt_q   <= '0;
            rr_ptr_q     <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            beat_cnt_q   <= beat_cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;

`ifdef RAM_ARB_STATS_EN
    logic [STAT_W-1:0] cnt_q [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_stats
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q[i] <= '0;
            end else if (req_ready[i] && req_valid[i] && (cnt_q[i] != '1)) begin
                cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
        assign grant_count[i*STAT_W +: STAT_W] = cnt_q[i];
    end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench: two arbiters (BURST_LEN 4 and 1) on shared stimulus, each with its own RAM model.
module tb_ram_port_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_we;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_wdata;

    logic [NREQ-1:0] rdy0, rv0, rdy1, rv1;
    logic [DW-1:0]   rd0, rd1, wd0, wd1, rram0, rram1;
    logic [AW-1:0]   wa0, ra0, wa1, ra1;
    logic            we0, we1;

    logic [DW-1:0] mem0 [256];
    logic [DW-1:0] mem1 [256];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .NREQ(NREQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(4)
    ) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy0), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv0), .resp_data(rd0),
        .ram_we(we0), .ram_write_addr(wa0), .ram_write_data(wd0), .ram_read_addr(ra0),
        .ram_read_data(rram0)
    );

    ram_port_arbiter #(
        .NREQ(NREQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv1), .resp_data(rd1),
        .ram_we(we1), .ram_write_addr(wa1), .ram_write_data(wd1), .ram_read_addr(ra1),
        .ram_read_data(rram1)
    );

    assign rram0 = mem0[ra0];
    assign rram1 = mem1[ra1];

    always @(posedge clk) begin
        if (we0) mem0[wa0] <= wd0;
        if (we1) mem1[wa1] <= wd1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Called at a negedge; returns at a later negedge with rst released.
    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_we    = '0;
        #1;
        check("rst ready", 64'(rdy0), 64'h0);
        check("rst resp_valid", 64'(rv0), 64'h0);
        check("rst resp_data", 64'(rd0), 64'h0);
        check("rst ram_we", 64'(we0), 64'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 32'hA500_0000 | 32'(i);
            mem1[i] = 32'hA500_0000 | 32'(i);
        end
        rst       = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        @(negedge clk);
        do_reset();

        // 1: single read by requester 0
        req_valid = 4'b0001;
        req_addr[0*AW +: AW] = 8'h10;
        #1;
        check("t1 ready", 64'(rdy0), 64'h1);
        check("t1 read_addr", 64'(ra0), 64'h10);
        @(posedge clk); #1;
        check("t1 resp_valid", 64'(rv0), 64'h1);
        check("t1 resp_data", 64'(rd0), 64'hA500_0010);
        @(negedge clk);
        req_valid = '0;
        @(posedge clk); #1;
        check("t1 resp_valid drop", 64'(rv0), 64'h0);

        // 2: requester 2 writes then reads 0x20
        @(negedge clk);
        req_valid = 4'b0100;
        req_we    = 4'b0100;
        req_addr[2*AW +: AW]  = 8'h20;
        req_wdata[2*DW +: DW] = 32'hDEAD_BEEF;
        #1;
        check("t2 ready", 64'(rdy0), 64'h4);
        check("t2 ram_we", 64'(we0), 64'h1);
        check("t2 waddr", 64'(wa0), 64'h20);
        check("t2 wdata", 64'(wd0), 64'hDEAD_BEEF);
        @(posedge clk); #1;
        check("t2 no resp on write", 64'(rv0), 64'h0);
        @(negedge clk);
        req_we = '0;
        #1;
        check("t2 read ready", 64'(rdy0), 64'h4);
        check("t2 read ram_we", 64'(we0), 64'h0);
        @(posedge clk); #1;
        check("t2 resp_valid", 64'(rv0), 64'h4);
        check("t2 resp_data", 64'(rd0), 64'hDEAD_BEEF);

        // 3: all valid, BURST_LEN=4 -> 4 beats per owner, rotating 0..3 then 0
        @(negedge clk);
        do_reset();
        req_valid = 4'b1111;
        req_we    = '0;
        for (int i = 0; i < 4; i++) req_addr[i*AW +: AW] = 8'(8'h30 + i);
        for (int c = 0; c < 20; c++) begin
            #1;
            check("t3 ready", 64'(rdy0), 64'(4'b0001 << ((c / 4) % 4)));
            @(posedge clk); #1;
            check("t3 resp_valid", 64'(rv0), 64'(4'b0001 << ((c / 4) % 4)));
            check("t3 resp_data", 64'(rd0), 64'(32'hA500_0030 + 32'((c / 4) % 4)));
            @(negedge clk);
        end

        // 4: BURST_LEN=1, requesters 1 (read) and 3 (write) alternate
        do_reset();
        req_valid = 4'b1010;
        req_we    = 4'b1000;
        req_addr[1*AW +: AW]  = 8'h41;
        req_addr[3*AW +: AW]  = 8'h40;
        req_wdata[3*DW +: DW] = 32'h1234_5678;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("t4 ready", 64'(rdy1), (c % 2 == 0) ? 64'h2 : 64'h8);
            check("t4 ram_we", 64'(we1), (c % 2 == 0) ? 64'h0 : 64'h1);
            @(posedge clk); #1;
            check("t4 resp_valid", 64'(rv1), (c % 2 == 0) ? 64'h2 : 64'h0);
            @(negedge clk);
        end

        // 5: owner 0 drops valid after 2 beats -> requester 1 same cycle, then rr_ptr=2
        do_reset();
        req_valid = 4'b0011;
        req_we    = '0;
        for (int c = 0; c < 2; c++) begin
            #1;
            check("t5 owner0 ready", 64'(rdy0), 64'h1);
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 4'b0010;
        #1;
        check("t5 switch ready", 64'(rdy0), 64'h2);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("t5 idle ready", 64'(rdy0), 64'h0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b0111;
        #1;
        check("t5 rr_ptr=2", 64'(rdy0), 64'h4);

        // 6: async reset mid-burst during a read
        @(negedge clk);
        do_reset();
        req_valid = 4'b0100;
        req_we    = '0;
        req_addr[2*AW +: AW] = 8'h22;
        #1;
        check("t6 ready", 64'(rdy0), 64'h4);
        @(posedge clk); #1;
        check("t6 resp_valid", 64'(rv0), 64'h4);
        @(negedge clk);
        #1;
        check("t6 mid-burst ready", 64'(rdy0), 64'h4);
        #1;
        rst = 1'b1;
        #1;
        check("t6 async ready", 64'(rdy0), 64'h0);
        check("t6 async resp_valid", 64'(rv0), 64'h0);
        check("t6 async ram_we", 64'(we0), 64'h0);
        @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 4'b1111;
        #1;
        check("t6 restart at 0", 64'(rdy0), 64'h1);
        @(posedge clk); #1;
        check("t6 restart resp", 64'(rv0), 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
